simon_score_keeper: RTL

- Upstream of the two-digit seven-segment decoder: tracks the Simon Says round score and the session best score, and drives the decoder's 6-bit `result_data` value.
- Consumes single-cycle game events from the game controller.
- Runs a three-state game-phase FSM and flashes the display after game over via a blink timer.

---
 rtl/simon_score_keeper_pkg.sv | 24 ++
 rtl/simon_score_keeper_if.sv | 31 +++
 rtl/simon_score_keeper_blink_timer.sv | 51 +++++
 rtl/simon_score_keeper.sv | 117 +++++++++++
 4 files changed

// File: rtl/simon_score_keeper_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simon_pkg : shared types and helpers for the Simon score keeper
// Rev 1.0
// ---------------------------------------------------------------------------
package simon_pkg;

  localparam int SCORE_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  function automatic logic [SCORE_W-1:0] sat_next_score(
    input logic [SCORE_W-1:0] score,
    input logic [SCORE_W-1:0] max_score
  );
    return (score >= max_score) ? max_score : score + SCORE_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simon_score_keeper_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simon_score_keeper_if : game events in, score/display status out
// Rev 1.0
// ---------------------------------------------------------------------------
interface simon_score_keeper_if;
  import simon_pkg::*;

  logic               start_game;
  logic               round_pass;
  logic               round_fail;
  logic               show_best;
  logic [SCORE_W-1:0] result_data;
  logic               game_active;
  logic               game_over;
  logic               won;
  logic               new_record;
  logic               display_blank;

  modport master (
    output start_game, round_pass, round_fail, show_best,
    input  result_data, game_active, game_over, won, new_record, display_blank
  );

  modport slave (
    input  start_game, round_pass, round_fail, show_best,
    output result_data, game_active, game_over, won, new_record, display_blank
  );

endinterface
`default_nettype wire

// File: rtl/simon_score_keeper_blink_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// blink_timer : toggles phase every PERIOD enabled cycles; clear wins
// Rev 1.0
// ---------------------------------------------------------------------------
module blink_timer #(
  parameter int PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic phase
);

  localparam int              CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/simon_score_keeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simon_score_keeper : game-phase FSM, round score and session best score
// Rev 1.0
// ---------------------------------------------------------------------------
module simon_score_keeper
  import simon_pkg::*;
#(
  parameter int MAX_SCORE    = 63,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  simon_score_keeper_if.slave bus
);

  localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] LAST_RND = SCORE_W'(MAX_SCORE - 1);

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               won_q, won_d;
  logic               new_record_q, new_record_d;
  logic               game_active_q, game_active_d;
  logic               game_over_q, game_over_d;
  logic               blink_clear;
  logic               blink_phase;

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    best_d       = best_q;
    won_d        = won_q;
    new_record_d = new_record_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_game) begin
          state_d = PLAY;
          score_d = '0;
        end
      end
      PLAY: begin
        if (bus.start_game) begin
          score_d = '0;
        end else if (bus.round_fail) begin
          state_d = OVER;
        end else if (bus.round_pass) begin
          score_d = sat_next_score(score_q, MAX_VAL);
          if (score_q == LAST_RND) begin
            won_d   = 1'b1;
            state_d = OVER;
          end
        end
      end
      OVER: begin
        if (bus.start_game) begin
          state_d      = PLAY;
          score_d      = '0;
          won_d        = 1'b0;
          new_record_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Record check uses the score being registered on the entry edge.
    if (state_q != OVER && state_d == OVER && score_d > best_q) begin
      best_d       = score_d;
      new_record_d = 1'b1;
    end

    game_active_d = (state_d == PLAY);
    game_over_d   = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      score_q       <= '0;
      best_q        <= '0;
      won_q         <= 1'b0;
      new_record_q  <= 1'b0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      best_q        <= best_d;
      won_q         <= won_d;
      new_record_q  <= new_record_d;
      game_active_q <= game_active_d;
      game_over_q   <= game_over_d;
    end
  end

  assign blink_clear = (state_q == OVER) != (state_d == OVER);

  blink_timer #(
    .PERIOD (BLINK_CYCLES)
  ) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == OVER),
    .clear  (blink_clear),
    .phase  (blink_phase)
  );

  assign bus.result_data   = bus.show_best ? best_q : score_q;
  assign bus.game_active   = game_active_q;
  assign bus.game_over     = game_over_q;
  assign bus.won           = won_q;
  assign bus.new_record    = new_record_q;
  assign bus.display_blank = blink_phase;

endmodule
`default_nettype wire
